// File: rtl/i2s_slave_rx.sv
// rtl/i2s_slave_rx.sv - I2S slave receiver: oversampled bclk/ws/data to a stereo AXI-Stream frame
// Left slot lands in tdata[SAMPLE_WIDTH-1:0], right slot in the upper half.
module i2s_slave_rx #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i2s_bclk,
  input  logic                      i2s_ws,
  input  logic                      i2s_data,
  output logic [2*SAMPLE_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      overflow,
  output logic                      short_slot,
  output logic [CNT_WIDTH-1:0]      overflow_count,
  output logic                      active
);

  localparam int BW = $clog2(SAMPLE_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] SW_CNT  = BW'(SAMPLE_WIDTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEFT,
    ST_RIGHT
  } state_t;

  state_t state_q, state_d;

  logic bclk_s1, bclk_s2, bclk_s3;
  logic ws_s1, ws_s2, ws_prev;
  logic data_s1, data_s2;

  logic [SAMPLE_WIDTH-1:0] shift_q, shift_ext, sample, left_hold;
  logic [BW-1:0]           bit_cnt, cnt_ext;
  logic [TW-1:0]           timeout_cnt;

  logic bclk_rise, boundary, timeout_hit, is_short;
  logic commit_left, commit_right, short_pulse;

  assign bclk_rise   = bclk_s2 & ~bclk_s3;
  assign boundary    = bclk_rise & (ws_s2 != ws_prev);
  assign timeout_hit = ~bclk_rise & (timeout_cnt == TO_LAST);

  // The boundary bit still belongs to the old slot, so the shift is resolved
  // before the commit value is formed.
  always_comb begin
    shift_ext = shift_q;
    cnt_ext   = bit_cnt;
    if (bit_cnt < SW_CNT) begin
      shift_ext = SAMPLE_WIDTH'({shift_q, data_s2});
      cnt_ext   = bit_cnt + BW'(1);
    end
    sample   = shift_ext << (SW_CNT - cnt_ext);
    is_short = cnt_ext < SW_CNT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    commit_left  = 1'b0;
    commit_right = 1'b0;
    short_pulse  = 1'b0;
    if (timeout_hit) begin
      state_d = ST_HUNT;
    end else if (boundary) begin
      case (state_q)
        ST_HUNT: begin
          if (!ws_s2) state_d = ST_LEFT;
        end
        ST_LEFT: begin
          state_d     = ST_RIGHT;
          commit_left = 1'b1;
          short_pulse = is_short;
        end
        ST_RIGHT: begin
          state_d      = ST_LEFT;
          commit_right = 1'b1;
          short_pulse  = is_short;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Input synchronizers, slot shift register and bit-clock watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bclk_s1     <= 1'b0;
      bclk_s2     <= 1'b0;
      bclk_s3     <= 1'b0;
      ws_s1       <= 1'b0;
      ws_s2       <= 1'b0;
      ws_prev     <= 1'b0;
      data_s1     <= 1'b0;
      data_s2     <= 1'b0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      timeout_cnt <= '0;
      left_hold   <= '0;
      active      <= 1'b0;
    end else begin
      bclk_s1 <= i2s_bclk;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      ws_s1   <= i2s_ws;
      ws_s2   <= ws_s1;
      data_s1 <= i2s_data;
      data_s2 <= data_s1;

      if (bclk_rise) begin
        timeout_cnt <= '0;
      end else if (timeout_cnt != TO_MAX) begin
        timeout_cnt <= timeout_cnt + TW'(1);
      end

      if (bclk_rise) begin
        if (boundary) begin
          shift_q <= '0;
          bit_cnt <= '0;
          ws_prev <= ws_s2;
        end else begin
          shift_q <= shift_ext;
          bit_cnt <= cnt_ext;
        end
      end else if (timeout_hit) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end

      if (commit_left) left_hold <= sample;
      active <= (state_d != ST_HUNT);
    end
  end

  // Output frame register; a frame arriving while the previous one is unaccepted is dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      overflow       <= 1'b0;
      short_slot     <= 1'b0;
      overflow_count <= '0;
    end else begin
      overflow   <= 1'b0;
      short_slot <= short_pulse;
      if (commit_right) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tdata  <= {sample, left_hold};
          m_axis_tvalid <= 1'b1;
        end else begin
          overflow <= 1'b1;
          if (overflow_count != {CNT_WIDTH{1'b1}}) begin
            overflow_count <= overflow_count + CNT_WIDTH'(1);
          end
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb/tb_i2s_slave_rx.sv - self-checking bench for i2s_slave_rx
// Streams are built as slot words, serialised with the I2S one-bit delay, and compared to a word-level model.
module tb_i2s_slave_rx;

  localparam int SW = 16;
  localparam int TO = 1024;
  localparam int H  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          i2s_bclk, i2s_ws, i2s_data;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready;
  logic          overflow, short_slot, active;
  logic [7:0]    overflow_count;

  i2s_slave_rx #(.SAMPLE_WIDTH(SW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .i2s_bclk(i2s_bclk), .i2s_ws(i2s_ws), .i2s_data(i2s_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .overflow(overflow), .short_slot(short_slot), .overflow_count(overflow_count),
    .active(active)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // stream description and serialised rises
  logic        s_ws[$];
  logic [31:0] s_word[$];
  int          s_len[$];
  logic        ws_r[$];
  logic        dat_r[$];
  int          rise_cyc[$];
  int          b2a_idx[$];
  int          pos;
  logic [31:0] exp_q[$];
  int          exp_short;

  // monitor results
  logic [31:0] got_q[$];
  int          tv_cyc[$];
  int          short_cnt, ovf_cnt;
  logic        prev_tv = 1'b0, prev_rdy = 1'b0;
  logic [31:0] prev_data = '0;
  logic        rand_ready = 1'b0;

  typedef struct {
    logic [31:0] lw;
    logic [31:0] rw;
    int          len;
    logic [31:0] exp;
    int          shorts_per_frame;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_sample(input logic [31:0] word, input int len);
    logic [31:0] v;
    v = word >> (32 - len);
    if (len >= 16) return 16'(v >> (len - 16));
    return 16'(v << (16 - len));
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (m_axis_tvalid && !prev_tv) tv_cyc.push_back(cyc);
      if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
      if (short_slot) short_cnt++;
      if (overflow) ovf_cnt++;
      if (prev_tv && !prev_rdy) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== prev_data) begin
          errors++;
          $display("FAIL hold_stable actual=%0b/%0h required=1/%0h", m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
    end
    prev_tv   = reset ? 1'b0 : m_axis_tvalid;
    prev_rdy  = m_axis_tready;
    prev_data = m_axis_tdata;
  end

  initial begin
    forever begin
      @(posedge clock); #2;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic new_stream();
    s_ws.delete(); s_word.delete(); s_len.delete();
    ws_r.delete(); dat_r.delete(); rise_cyc.delete(); b2a_idx.delete();
    exp_q.delete(); exp_short = 0; pos = 0;
  endtask

  task automatic add_slot(input logic w, input logic [31:0] word, input int len);
    s_ws.push_back(w); s_word.push_back(word); s_len.push_back(len);
  endtask

  task automatic add_dummy();
    add_slot(1'b1, $urandom, 5);
  endtask

  task automatic add_frame(input logic [31:0] lw, input logic [31:0] rw, input int ll, input int rl);
    add_slot(1'b0, lw, ll);
    add_slot(1'b1, rw, rl);
    exp_q.push_back({exp_sample(rw, rl), exp_sample(lw, ll)});
    if (ll < SW) exp_short++;
    if (rl < SW) exp_short++;
  endtask

  // data trails ws by one rise; a final rise with ws toggled closes the last slot
  task automatic finalize();
    logic b[$];
    for (int i = 0; i < s_ws.size(); i++)
      for (int j = 0; j < s_len[i]; j++) begin
        ws_r.push_back(s_ws[i]);
        b.push_back(s_word[i][31-j]);
      end
    dat_r.push_back(1'($urandom_range(0, 1)));
    for (int i = 1; i < b.size(); i++) dat_r.push_back(b[i-1]);
    ws_r.push_back(~s_ws[s_ws.size()-1]);
    dat_r.push_back(b[b.size()-1]);
    for (int i = 1; i < ws_r.size(); i++)
      if (ws_r[i-1] && !ws_r[i]) b2a_idx.push_back(i);
  endtask

  task automatic play(input int n);
    @(posedge clock); #2;
    for (int k = 0; k < n && pos < ws_r.size(); k++) begin
      i2s_ws   = ws_r[pos];
      i2s_data = dat_r[pos];
      repeat (H) @(posedge clock);
      #2 i2s_bclk = 1'b1;
      rise_cyc.push_back(cyc);
      repeat (H) @(posedge clock);
      #2 i2s_bclk = 1'b0;
      pos++;
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); tv_cyc.delete(); short_cnt = 0; ovf_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clock); #2 reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  task automatic compare_frames(input string name);
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({name, "_frame"}, 64'(got_q[i]), 64'(exp_q[i]));
    check({name, "_short"}, 64'(short_cnt), 64'(exp_short));
  endtask

  initial begin
    vecs[0] = '{32'h1234_5A5A, 32'hABCD_C3C3, 32, 32'hABCD_1234, 0};
    vecs[1] = '{32'h8001_0000, 32'h7FFE_0000, 16, 32'h7FFE_8001, 0};
    vecs[2] = '{32'hABC0_0000, 32'h5670_0000, 12, 32'h5670_ABC0, 2};
    vecs[3] = '{32'hFFFF_8000, 32'h0001_0000, 17, 32'h0001_FFFF, 0};
    vecs[4] = '{32'hA500_0000, 32'h5A00_0000,  8, 32'h5A00_A500, 2};

    reset = 1'b1; i2s_bclk = 1'b0; i2s_ws = 1'b0; i2s_data = 1'b0; m_axis_tready = 1'b1;
    wait_cycles(3);
    check("rst_tdata", 64'(m_axis_tdata), 64'h0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_short", 64'(short_slot), 64'h0);
    check("rst_count", 64'(overflow_count), 64'h0);
    check("rst_active", 64'(active), 64'h0);
    reset = 1'b0;

    // table: partial right slot after reset, then two identical frames
    for (int v = 0; v < 5; v++) begin
      do_reset();
      new_stream();
      add_dummy();
      add_frame(vecs[v].lw, vecs[v].rw, vecs[v].len, vecs[v].len);
      add_frame(vecs[v].lw, vecs[v].rw, vecs[v].len, vecs[v].len);
      finalize();
      clear_mon();
      play(5);
      wait_cycles(4);
      check("tbl_active_hunt", 64'(active), 64'h0);
      play(100000);
      wait_cycles(8);
      check("tbl_count", 64'(got_q.size()), 64'd2);
      for (int i = 0; i < got_q.size() && i < 2; i++)
        check("tbl_frame", 64'(got_q[i]), 64'(vecs[v].exp));
      check("tbl_short", 64'(short_cnt), 64'(2 * vecs[v].shorts_per_frame));
      check("tbl_overflow", 64'(ovf_cnt), 64'd0);
      check("tbl_active", 64'(active), 64'h1);
      if (v == 0) begin
        check("tvalid_pulses", 64'(tv_cyc.size()), 64'd2);
        if (tv_cyc.size() >= 2 && b2a_idx.size() >= 3) begin
          check("latency0", 64'(tv_cyc[0] - rise_cyc[b2a_idx[1]]), 64'd3);
          check("latency1", 64'(tv_cyc[1] - rise_cyc[b2a_idx[2]]), 64'd3);
        end
      end
    end

    // backpressure: three frames while tready=0, then release
    do_reset();
    new_stream();
    add_dummy();
    for (int f = 1; f <= 5; f++) add_frame(32'h1111_0000 * f, 32'h0F0F_0000 + 32'(f) << 16, 16, 16);
    finalize();
    clear_mon();
    m_axis_tready = 1'b0;
    fork
      play(100000);
      begin
        int n;
        n = 0;
        while (ovf_cnt < 2 && n < 3000) begin
          wait_cycles(1);
          n++;
        end
        check("bp_ovf_seen", 64'(ovf_cnt), 64'd2);
        check("bp_held_valid", 64'(m_axis_tvalid), 64'h1);
        check("bp_held_data", 64'(m_axis_tdata), 64'(exp_q[0]));
        check("bp_count", 64'(overflow_count), 64'd2);
        m_axis_tready = 1'b1;
      end
    join
    wait_cycles(8);
    check("bp_frames", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("bp_f0", 64'(got_q[0]), 64'(exp_q[0]));
      check("bp_f1", 64'(got_q[1]), 64'(exp_q[3]));
      check("bp_f2", 64'(got_q[2]), 64'(exp_q[4]));
    end
    check("bp_ovf_total", 64'(ovf_cnt), 64'd2);

    // timeout then realign without reset
    do_reset();
    new_stream();
    add_dummy();
    add_frame($urandom, $urandom, 32, 32);
    add_frame($urandom, $urandom, 32, 32);
    finalize();
    clear_mon();
    play(100000);
    wait_cycles(8);
    compare_frames("to_pre");
    check("to_active_pre", 64'(active), 64'h1);
    wait_cycles(TO + 20);
    check("to_active_drop", 64'(active), 64'h0);
    new_stream();
    add_dummy();
    add_frame($urandom, $urandom, 24, 20);
    add_frame($urandom, $urandom, 32, 16);
    finalize();
    clear_mon();
    play(100000);
    wait_cycles(8);
    compare_frames("to_post");
    check("to_active_post", 64'(active), 64'h1);

    // reset in the middle of a left slot
    do_reset();
    new_stream();
    add_dummy();
    add_frame(32'hDEAD_0000, 32'hBEEF_0000, 32, 32);
    add_frame(32'h1357_0000, 32'h2468_0000, 32, 32);
    finalize();
    clear_mon();
    play(5 + 64 + 16);
    wait_cycles(6);
    check("mid_first", 64'(m_axis_tdata), 64'hBEEF_DEAD);
    reset = 1'b1;
    #1;
    check("mid_rst_tdata", 64'(m_axis_tdata), 64'h0);
    check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    check("mid_rst_active", 64'(active), 64'h0);
    wait_cycles(2);
    reset = 1'b0;
    new_stream();
    add_dummy();
    add_frame($urandom, $urandom, 32, 32);
    add_frame($urandom, $urandom, 32, 32);
    finalize();
    clear_mon();
    play(100000);
    wait_cycles(8);
    compare_frames("mid_resume");

    // randomized slot lengths, data and tready
    for (int it = 0; it < 3; it++) begin
      do_reset();
      new_stream();
      add_dummy();
      for (int f = 0; f < 6; f++)
        add_frame($urandom, $urandom, $urandom_range(8, 32), $urandom_range(8, 32));
      finalize();
      clear_mon();
      rand_ready = 1'b1;
      play(100000);
      wait_cycles(40);
      rand_ready = 1'b0;
      m_axis_tready = 1'b1;
      wait_cycles(4);
      compare_frames("rnd");
      check("rnd_overflow", 64'(ovf_cnt), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
